// File: rtl/sys_arr_load_sequencer.sv
// sys_arr_load_sequencer
// Feeds the systolic array load ports from a command stream and a row stream.
// A command either loads N weight rows, waits for the array to drain, then
// sends an input tile, or sends an input tile once the array FIFO has space.
// Optional statistics counters are built when SYS_ARR_LOAD_STATS_EN is defined.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; valid may rise at any time, ready never depends combinationally on
// valid, and data is only sampled on the transfer edge.
module sys_arr_load_sequencer #(
  parameter int N   = 4,
  parameter int DW  = 32,
  parameter int IND = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   nRST,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_weights,
  input  logic [$clog2(N):0]     cmd_rows,
  input  logic                   row_valid,
  output logic                   row_ready,
  input  logic [N*DW-1:0]        row_vals,
  input  logic [N*IND-1:0]       row_inds,
  input  logic [N-1:0]           row_ends,
  input  logic [N*DW-1:0]        row_partials,
  input  logic                   drained,
  input  logic                   fifo_has_space,
  output logic                   weight_en,
  output logic                   input_en,
  output logic                   partial_en,
  output logic [$clog2(N)-1:0]   row_in_en,
  output logic [N*DW-1:0]        vals_in,
  output logic [N*IND-1:0]       inds_in,
  output logic [N-1:0]           ends_in,
  output logic [N*DW-1:0]        array_in_partials,
  output logic                   busy,
`ifdef SYS_ARR_LOAD_STATS_EN
  output logic [31:0]            tiles_done,
  output logic [31:0]            stall_cycles,
`endif
  output logic [2:0]             state_dbg
);

  localparam int RW = $clog2(N);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WLOAD  = 3'd1,
    S_WDRAIN = 3'd2,
    S_IWAIT  = 3'd3,
    S_IACC   = 3'd4,
    S_IGAP   = 3'd5,
    S_TAIL   = 3'd6
  } state_t;

  state_t          state;
  logic [RW-1:0]   wrow;
  logic [CW-1:0]   irows;
  logic [CW-1:0]   icnt;
  logic            first_row;
  logic [CW-1:0]   rows_eff;
  logic            row_xfer;

  // Zero or out-of-range row counts mean a full tile of N rows.
  always_comb begin
    rows_eff = cmd_rows;
    if (cmd_rows == '0 || cmd_rows > CW'(N)) rows_eff = CW'(N);
  end

  assign cmd_ready = nRST && (state == S_IDLE);
  assign row_ready = nRST && ((state == S_WLOAD) || (state == S_IACC));
  assign row_xfer  = row_valid && row_ready;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Control FSM and registered array-side outputs.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state             <= S_IDLE;
      wrow              <= '0;
      irows             <= '0;
      icnt              <= '0;
      first_row         <= 1'b0;
      weight_en         <= 1'b0;
      input_en          <= 1'b0;
      partial_en        <= 1'b0;
      row_in_en         <= '0;
      vals_in           <= '0;
      inds_in           <= '0;
      ends_in           <= '0;
      array_in_partials <= '0;
    end else begin
      // Strobes are single-cycle; value buses return to zero between strobes.
      weight_en         <= 1'b0;
      input_en          <= 1'b0;
      partial_en        <= 1'b0;
      vals_in           <= '0;
      array_in_partials <= '0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            irows     <= rows_eff;
            icnt      <= '0;
            wrow      <= '0;
            first_row <= 1'b1;
            state     <= cmd_weights ? S_WLOAD : S_IWAIT;
          end
        end
        S_WLOAD: begin
          if (row_xfer) begin
            weight_en <= 1'b1;
            row_in_en <= wrow;
            vals_in   <= row_vals;
            inds_in   <= row_inds;
            if (wrow == RW'(N - 1)) begin
              wrow  <= '0;
              state <= S_WDRAIN;
            end else begin
              wrow <= wrow + RW'(1);
            end
          end
        end
        S_WDRAIN: begin
          if (drained) state <= S_IACC;
        end
        S_IWAIT: begin
          if (fifo_has_space) state <= S_IACC;
        end
        S_IACC: begin
          if (row_xfer) begin
            input_en  <= 1'b1;
            row_in_en <= '0;
            vals_in   <= row_vals;
            inds_in   <= row_inds;
            ends_in   <= row_ends;
            if (first_row) begin
              partial_en        <= 1'b1;
              array_in_partials <= row_partials;
            end
            first_row <= 1'b0;
            icnt      <= icnt + CW'(1);
            state     <= S_IGAP;
          end
        end
        S_IGAP: begin
          state <= (icnt == irows) ? S_TAIL : S_IACC;
        end
        S_TAIL: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SYS_ARR_LOAD_STATS_EN
  logic stall_now;
  assign stall_now = (state == S_WDRAIN) || (state == S_IWAIT) ||
                     ((state == S_IACC) && !row_valid);

  // Saturating tile and stall counters.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      tiles_done   <= '0;
      stall_cycles <= '0;
    end else begin
      if ((state == S_TAIL) && (tiles_done != '1)) tiles_done <= tiles_done + 32'd1;
      if (stall_now && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sys_arr_load_sequencer.sv
// Self-checking bench for sys_arr_load_sequencer (N=4, DW=32).
module tb_sys_arr_load_sequencer;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int IND = 2;
  localparam int CW  = 3;
  localparam int W   = 3 + IND + 2 * N * DW + N * IND + N;

  logic              tb_clk;
  logic              nRST;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_weights;
  logic [CW-1:0]     cmd_rows;
  logic              row_valid;
  logic              row_ready;
  logic [N*DW-1:0]   row_vals;
  logic [N*IND-1:0]  row_inds;
  logic [N-1:0]      row_ends;
  logic [N*DW-1:0]   row_partials;
  logic              drained;
  logic              fifo_has_space;
  logic              weight_en;
  logic              input_en;
  logic              partial_en;
  logic [IND-1:0]    row_in_en;
  logic [N*DW-1:0]   vals_in;
  logic [N*IND-1:0]  inds_in;
  logic [N-1:0]      ends_in;
  logic [N*DW-1:0]   array_in_partials;
  logic              busy;
  logic [2:0]        state_dbg;
`ifdef SYS_ARR_LOAD_STATS_EN
  logic [31:0]       tiles_done;
  logic [31:0]       stall_cycles;
`endif

  sys_arr_load_sequencer #(.N(N), .DW(DW)) dut (
    .clk               (tb_clk),
    .nRST              (nRST),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_weights       (cmd_weights),
    .cmd_rows          (cmd_rows),
    .row_valid         (row_valid),
    .row_ready         (row_ready),
    .row_vals          (row_vals),
    .row_inds          (row_inds),
    .row_ends          (row_ends),
    .row_partials      (row_partials),
    .drained           (drained),
    .fifo_has_space    (fifo_has_space),
    .weight_en         (weight_en),
    .input_en          (input_en),
    .partial_en        (partial_en),
    .row_in_en         (row_in_en),
    .vals_in           (vals_in),
    .inds_in           (inds_in),
    .ends_in           (ends_in),
    .array_in_partials (array_in_partials),
    .busy              (busy),
`ifdef SYS_ARR_LOAD_STATS_EN
    .tiles_done        (tiles_done),
    .stall_cycles      (stall_cycles),
`endif
    .state_dbg         (state_dbg)
  );

  // Clock and cycle counter
  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  int cyc = 0;
  always @(posedge tb_clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [W-1:0]     exp_q[$];
  int               exp_cyc_q[$];
  int               vec  = 0;
  int               misc = 0;
  bit               mon_en = 1'b0;
  logic [N*IND-1:0] m_inds;
  logic [N-1:0]     m_ends;
  int               last_acc;
  int               first_acc;

  function automatic logic [W-1:0] pack(input logic we, input logic ie, input logic pe,
                                        input logic [IND-1:0] rie, input logic [N*DW-1:0] v,
                                        input logic [N*IND-1:0] ix, input logic [N-1:0] e,
                                        input logic [N*DW-1:0] p);
    return {we, ie, pe, rie, v, ix, e, p};
  endfunction

  // Output monitor: compares each strobe cycle against the expected queue
  always @(negedge tb_clk) begin
    logic [W-1:0] obs;
    logic [W-1:0] e;
    int           ec;
    if (mon_en) begin
      obs = {weight_en, input_en, partial_en, row_in_en, vals_in, inds_in, ends_in, array_in_partials};
      if (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        vec++;
        if (ec != cyc || obs !== e) begin
          misc++;
          $display("FAIL strobe_row cyc=%0d exp_cyc=%0d got=%h exp=%h", cyc, ec, obs, e);
        end
      end else begin
        vec++;
        if ({weight_en, input_en, partial_en} !== 3'b000) begin
          misc++;
          $display("FAIL unexpected_strobe cyc=%0d got=%b exp=000", cyc, {weight_en, input_en, partial_en});
        end
      end
      if (!weight_en && !input_en) begin
        vec++;
        if (vals_in !== '0) begin
          misc++;
          $display("FAIL vals_idle_zero cyc=%0d got=%h exp=0", cyc, vals_in);
        end
      end
      if (!partial_en) begin
        vec++;
        if (array_in_partials !== '0) begin
          misc++;
          $display("FAIL partials_idle_zero cyc=%0d got=%h exp=0", cyc, array_in_partials);
        end
      end
    end
  end

  // Driver: one command, waits for cmd_ready with a bound
  task automatic send_cmd(input logic w, input logic [CW-1:0] rc);
    int t = 0;
    cmd_valid = 1'b1; cmd_weights = w; cmd_rows = rc;
    while (!cmd_ready && t < 100) begin @(negedge tb_clk); t++; end
    if (!cmd_ready) begin
      misc++; vec++;
      $display("FAIL cmd_timeout got=cmd_ready0 exp=cmd_ready1");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge tb_clk); #1;
    cmd_valid = 1'b0;
    vec++;
    if (busy !== 1'b1) begin
      misc++;
      $display("FAIL busy_after_cmd got=%b exp=1", busy);
    end
  endtask

  // Driver: one row, optional idle slots first; pushes the expected strobe
  task automatic drive_row(input bit is_w, input int r, input bit first, input int pre_idle);
    logic [N*DW-1:0]  v;
    logic [N*DW-1:0]  p;
    logic [N*IND-1:0] ix;
    logic [N-1:0]     e;
    int               t = 0;
    for (int i = 0; i < N; i++) begin
      v[i*DW +: DW] = $urandom | 32'h1;
      p[i*DW +: DW] = $urandom | 32'h1;
    end
    ix = (N*IND)'($urandom_range(0, 255));
    e  = N'($urandom_range(0, 15));
    if (pre_idle > 0) begin
      row_valid = 1'b0;
      repeat (pre_idle) @(negedge tb_clk);
    end
    row_vals = v; row_inds = ix; row_ends = e; row_partials = p;
    row_valid = 1'b1;
    while (!row_ready && t < 200) begin @(negedge tb_clk); t++; end
    if (!row_ready) begin
      misc++; vec++;
      $display("FAIL row_timeout got=row_ready0 exp=row_ready1");
      row_valid = 1'b0;
      return;
    end
    @(posedge tb_clk); #1;
    row_valid = 1'b0;
    if (is_w) begin
      m_inds = ix;
      exp_q.push_back(pack(1'b1, 1'b0, 1'b0, IND'(r), v, ix, m_ends, '0));
    end else begin
      if (!first) begin
        vec++;
        if (cyc - last_acc < 2) begin
          misc++;
          $display("FAIL input_gap got=%0d exp>=2", cyc - last_acc);
        end
      end
      m_inds = ix; m_ends = e;
      exp_q.push_back(pack(1'b0, 1'b1, first, '0, v, ix, e, first ? p : '0));
    end
    exp_cyc_q.push_back(cyc);
    last_acc = cyc;
  endtask

  // N weight rows back to back; each must be accepted one cycle after the previous
  task automatic run_weights();
    int prev;
    for (int r = 0; r < N; r++) begin
      drive_row(1'b1, r, 1'b0, 0);
      if (r > 0) begin
        vec++;
        if (last_acc !== prev + 1) begin
          misc++;
          $display("FAIL weight_back_to_back row=%0d got=%0d exp=%0d", r, last_acc, prev + 1);
        end
      end
      prev = last_acc;
    end
  endtask

  task automatic run_inputs(input int n, input int drop_at, input int drop_len);
    for (int i = 0; i < n; i++) begin
      drive_row(1'b0, 0, i == 0, (i == drop_at) ? drop_len : 0);
      if (i == 0) first_acc = last_acc;
    end
  endtask

  // Tile must end: busy drops exactly two cycles after the last accepted row
  task automatic wait_tail();
    int t = 0;
    while (busy && t < 50) begin @(negedge tb_clk); t++; end
    vec++;
    if (cyc !== last_acc + 2 || busy !== 1'b0) begin
      misc++;
      $display("FAIL tail_timing got=cyc%0d busy%b exp=cyc%0d busy0", cyc, busy, last_acc + 2);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (2) @(posedge tb_clk);
    @(negedge tb_clk);
    vec++;
    if ({weight_en, input_en, partial_en, row_in_en, vals_in, inds_in, ends_in, array_in_partials} !== '0) begin
      misc++;
      $display("FAIL reset_outputs got=nonzero exp=0");
    end
    vec++;
    if ({cmd_ready, row_ready, busy} !== 3'b000) begin
      misc++;
      $display("FAIL reset_handshake got=%b exp=000", {cmd_ready, row_ready, busy});
    end
    m_inds = '0; m_ends = '0;
    mon_en = 1'b1;
    nRST = 1'b1;
    @(posedge tb_clk); #1;
    vec++;
    if ({cmd_ready, busy} !== 2'b10) begin
      misc++;
      $display("FAIL idle_after_reset got=%b exp=10", {cmd_ready, busy});
    end
  endtask

  task automatic test_weight_tile();
    int lw;
    drained = 1'b1;
    send_cmd(1'b1, 3'd2);
    run_weights();
    lw = last_acc;
    run_inputs(2, -1, 0);
    vec++;
    if (first_acc !== lw + 2) begin
      misc++;
      $display("FAIL wdrain_skip got=%0d exp=%0d", first_acc, lw + 2);
    end
    wait_tail();
  endtask

  task automatic test_iwait();
    int c;
    fifo_has_space = 1'b0;
    send_cmd(1'b0, 3'd2);
    repeat (5) begin
      @(negedge tb_clk);
      vec++;
      if ({busy, row_ready} !== 2'b10) begin
        misc++;
        $display("FAIL iwait_hold got=%b exp=10", {busy, row_ready});
      end
    end
    fifo_has_space = 1'b1;
    c = cyc;
    run_inputs(2, -1, 0);
    vec++;
    if (first_acc !== c + 2) begin
      misc++;
      $display("FAIL iwait_release got=%0d exp=%0d", first_acc, c + 2);
    end
    wait_tail();
  endtask

  task automatic test_drain_wait();
    int c;
    drained = 1'b0;
    send_cmd(1'b1, 3'd1);
    run_weights();
    repeat (10) begin
      @(negedge tb_clk);
      vec++;
      if ({busy, row_ready} !== 2'b10) begin
        misc++;
        $display("FAIL wdrain_hold got=%b exp=10", {busy, row_ready});
      end
    end
    drained = 1'b1;
    c = cyc;
    run_inputs(1, -1, 0);
    vec++;
    if (first_acc !== c + 2) begin
      misc++;
      $display("FAIL wdrain_release got=%0d exp=%0d", first_acc, c + 2);
    end
    wait_tail();
  endtask

  task automatic test_row_stall();
    send_cmd(1'b0, 3'd4);
    run_inputs(4, 2, 4);
    wait_tail();
  endtask

  task automatic test_mid_reset();
    drained = 1'b1;
    send_cmd(1'b1, 3'd4);
    drive_row(1'b1, 0, 1'b0, 0);
    drive_row(1'b1, 1, 1'b0, 0);
    nRST = 1'b0;
    @(negedge tb_clk);
    @(negedge tb_clk);
    vec++;
    if ({weight_en, input_en, partial_en, row_in_en, vals_in, inds_in, ends_in, array_in_partials} !== '0) begin
      misc++;
      $display("FAIL mid_reset_outputs got=nonzero exp=0");
    end
    vec++;
    if ({cmd_ready, row_ready, busy} !== 3'b000) begin
      misc++;
      $display("FAIL mid_reset_handshake got=%b exp=000", {cmd_ready, row_ready, busy});
    end
    m_inds = '0; m_ends = '0;
    nRST = 1'b1;
    #1;
    vec++;
    if (cmd_ready !== 1'b1) begin
      misc++;
      $display("FAIL mid_reset_cmd_ready got=%b exp=1", cmd_ready);
    end
    send_cmd(1'b1, 3'd2);
    run_weights();
    run_inputs(2, -1, 0);
    wait_tail();
  endtask

  task automatic test_clamp();
    send_cmd(1'b0, 3'd0);
    run_inputs(4, -1, 0);
    wait_tail();
    send_cmd(1'b0, 3'd7);
    run_inputs(4, -1, 0);
    wait_tail();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      logic [CW-1:0] rc;
      rc = CW'($urandom_range(1, 4));
      send_cmd(k[0], rc);
      if (k[0]) run_weights();
      run_inputs(int'(rc), -1, 0);
      wait_tail();
    end
  endtask

  initial begin
    nRST = 1'b0; cmd_valid = 1'b0; cmd_weights = 1'b0; cmd_rows = '0;
    row_valid = 1'b0; row_vals = '0; row_inds = '0; row_ends = '0; row_partials = '0;
    drained = 1'b1; fifo_has_space = 1'b1;
    test_reset();
    test_weight_tile();
    test_iwait();
    test_drain_wait();
    test_row_stall();
    test_mid_reset();
    test_clamp();
    test_back_to_back();
    repeat (4) @(negedge tb_clk);
    vec++;
    if (exp_q.size() != 0) begin
      misc++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, misc);
    $finish;
  end

endmodule
